// File: rtl/raven_pe_pkg.sv
// Shared fixed-point constants and requantization helper for the PE array datapath.
package raven_pe_pkg;

    localparam int unsigned PE_INT_BW = 5;
    localparam int unsigned PE_FRA_BW = 10;
    localparam int unsigned PE_MUL_BW = 1 + PE_INT_BW + PE_FRA_BW;
    localparam int unsigned PE_ACC_BW = 32;

    // Saturation bounds of the MUL_BW format, expressed at accumulator width.
    localparam logic signed [PE_ACC_BW-1:0] ACC_SAT_MAX =
        {{(PE_ACC_BW-PE_MUL_BW+1){1'b0}}, {(PE_MUL_BW-1){1'b1}}};
    localparam logic signed [PE_ACC_BW-1:0] ACC_SAT_MIN =
        {{(PE_ACC_BW-PE_MUL_BW+1){1'b1}}, {(PE_MUL_BW-1){1'b0}}};

    typedef struct packed {
        logic                 sat;
        logic [PE_MUL_BW-1:0] val;
    } req_t;

    function automatic req_t sat_requant(input logic signed [PE_ACC_BW-1:0] acc);
        logic signed [PE_ACC_BW-1:0] t;
        req_t r;
        t = acc >>> PE_FRA_BW;
        if (t > ACC_SAT_MAX) begin
            r.val = {1'b0, {(PE_MUL_BW-1){1'b1}}};
            r.sat = 1'b1;
        end else if (t < ACC_SAT_MIN) begin
            r.val = {1'b1, {(PE_MUL_BW-1){1'b0}}};
            r.sat = 1'b1;
        end else begin
            r.val = t[PE_MUL_BW-1:0];
            r.sat = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_drain_fifo.sv
// Synchronous row FIFO; a push into a full FIFO is accepted only alongside a pop.
module pe_drain_fifo #(
    parameter int unsigned WIDTH = 68,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign count   = cnt_q;
    assign rdata   = empty ? '0 : mem[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      cnt_q <= cnt_q + 1'b1;
            else if (!push_ok && pop_ok) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clr) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/pe_drain.sv
// Drains the skewed bottom row of the PE array: de-skew, saturating requant, row FIFO.
module pe_drain
    import raven_pe_pkg::*;
#(
    parameter int unsigned INT_BW = PE_INT_BW,
    parameter int unsigned FRA_BW = PE_FRA_BW,
    parameter int unsigned MUL_BW = PE_MUL_BW,
    parameter int unsigned ACC_BW = PE_ACC_BW,
    parameter int unsigned COLS   = 4,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic [COLS*ACC_BW-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [COLS*MUL_BW-1:0]   out_data,
    output logic [COLS-1:0]          out_sat,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic                     ovf_err
);

    localparam int unsigned ROW_W = COLS * (MUL_BW + 1);

    logic [ACC_BW-1:0]      aligned [COLS];
    logic                   aligned_valid;
    logic [COLS*MUL_BW-1:0] row_data;
    logic [COLS-1:0]        row_sat;
    req_t                   req;

    logic                   sat_valid_q;
    logic [COLS*MUL_BW-1:0] sat_data_q;
    logic [COLS-1:0]        sat_flag_q;
    logic                   ovf_q;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [ROW_W-1:0]       fifo_rdata;

    // Lane j arrives j cycles late, so it needs COLS-1-j stages to line up with lane COLS-1.
    for (genvar j = 0; j < COLS; j++) begin : g_lane
        localparam int unsigned STAGES = COLS - 1 - j;
        if (STAGES == 0) begin : g_direct
            assign aligned[j] = in_data[j*ACC_BW +: ACC_BW];
        end else begin : g_dly
            logic [ACC_BW-1:0] dly_q [STAGES];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < STAGES; i++) dly_q[i] <= '0;
                end else begin
                    dly_q[0] <= in_data[j*ACC_BW +: ACC_BW];
                    for (int i = 1; i < STAGES; i++) dly_q[i] <= dly_q[i-1];
                end
            end
            assign aligned[j] = dly_q[STAGES-1];
        end
    end

    if (COLS == 1) begin : g_vld_direct
        assign aligned_valid = in_valid;
    end else begin : g_vld_chain
        logic [COLS-2:0] vld_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
            end else if (clr) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= in_valid;
                for (int i = 1; i < COLS - 1; i++) vld_q[i] <= vld_q[i-1];
            end
        end
        assign aligned_valid = vld_q[COLS-2];
    end

    always_comb begin
        row_data = '0;
        row_sat  = '0;
        req      = '0;
        for (int j = 0; j < COLS; j++) begin
            req                         = sat_requant(aligned[j]);
            row_data[j*MUL_BW +: MUL_BW] = req.val;
            row_sat[j]                  = req.sat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_valid_q <= 1'b0;
            sat_data_q  <= '0;
            sat_flag_q  <= '0;
        end else begin
            sat_valid_q <= aligned_valid && !clr;
            sat_data_q  <= row_data;
            sat_flag_q  <= row_sat;
        end
    end

    // A full FIFO only accepts the row if the head leaves on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (clr) begin
            ovf_q <= 1'b0;
        end else if (sat_valid_q && fifo_full && !out_ready) begin
            ovf_q <= 1'b1;
        end
    end

    pe_drain_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (sat_valid_q),
        .pop   (out_ready),
        .wdata ({sat_flag_q, sat_data_q}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_rdata[COLS*MUL_BW-1:0];
    assign out_sat   = fifo_rdata[ROW_W-1 -: COLS];
    assign ovf_err   = ovf_q;

endmodule
